// File: rtl/tm_slave_multimaster.sv
//------------------------------------------------------------------------------
// Module      : tm_slave_multimaster
// Description : Slave-side credit shell. Forwards NoC request flits to a slave
//               module, remembers each request's return tag {src_vc, src} in an
//               in-order FIFO and stamps the head tag onto each module reply so
//               the reply (and its credit) goes back to the requesting master.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tm_slave_multimaster #(
  parameter int NUM_CREDITS      = 32,
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 2,
  parameter int WIDTH_NOC        = 36
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid_in,
  input  logic [WIDTH_NOC-1:0]                 req_data_in,
  input  logic [ADDRESS_WIDTH-1:0]             req_src,
  input  logic [VC_ADDRESS_WIDTH-1:0]          req_src_vc,
  output logic                                 req_ready_out,
  output logic                                 req_valid_out,
  output logic [WIDTH_NOC-1:0]                 req_data_out,
  input  logic                                 req_ready_in,
  input  logic                                 rsp_valid_in,
  input  logic [WIDTH_NOC-1:0]                 rsp_data_in,
  output logic                                 rsp_ready_out,
  output logic                                 rsp_valid_out,
  output logic [WIDTH_NOC-1:0]                 rsp_data_out,
  output logic [ADDRESS_WIDTH-1:0]             rsp_dest,
  output logic [VC_ADDRESS_WIDTH-1:0]          rsp_vc,
  input  logic                                 rsp_ready_in,
  output logic [$clog2(NUM_CREDITS+1)-1:0]     num_outstanding
);

  localparam int c_PTR_W = (NUM_CREDITS > 1) ? $clog2(NUM_CREDITS) : 1;
  localparam int c_CNT_W = $clog2(NUM_CREDITS + 1);
  localparam int c_TAG_W = VC_ADDRESS_WIDTH + ADDRESS_WIDTH;
  localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(NUM_CREDITS - 1);
  localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(NUM_CREDITS);

  logic [c_TAG_W-1:0] r_tag_mem [NUM_CREDITS];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic               r_req_valid;
  logic [WIDTH_NOC-1:0] r_req_data;
  logic               r_rsp_valid;
  logic [WIDTH_NOC-1:0] r_rsp_data;
  logic [c_TAG_W-1:0] r_rsp_tag;

  logic               w_push;
  logic               w_pop;
  logic               w_not_full;
  logic               w_not_empty;
  logic [c_TAG_W-1:0] w_rd_tag;

  // Ready terms are gated by reset so every output reads 0 while rst is low.
  // Full blocks requests even when a pop happens in the same cycle.
  assign w_not_full    = (r_count < c_FULL_CNT);
  assign w_not_empty   = (r_count != '0);
  assign req_ready_out = rst & (~r_req_valid | req_ready_in) & w_not_full;
  assign rsp_ready_out = rst & (~r_rsp_valid | rsp_ready_in) & w_not_empty;

  assign w_push   = req_valid_in & req_ready_out;
  assign w_pop    = rsp_valid_in & rsp_ready_out;
  assign w_rd_tag = r_tag_mem[r_rd_ptr];

  assign req_valid_out   = r_req_valid;
  assign req_data_out    = r_req_data;
  assign rsp_valid_out   = r_rsp_valid;
  assign rsp_data_out    = r_rsp_data;
  assign {rsp_vc, rsp_dest} = r_rsp_tag;
  assign num_outstanding = r_count;

  // Tag storage: written on request accept, contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= {req_src_vc, req_src};
    end
  end

  // FIFO pointers with explicit wrap and occupancy counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Request output register toward the slave module.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_valid <= 1'b0;
      r_req_data  <= '0;
    end else if (w_push) begin
      r_req_valid <= 1'b1;
      r_req_data  <= req_data_in;
    end else if (req_ready_in) begin
      r_req_valid <= 1'b0;
    end
  end

  // Reply output register toward the NoC; cleared once the flit drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_tag   <= '0;
    end else if (w_pop) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= rsp_data_in;
      r_rsp_tag   <= w_rd_tag;
    end else if (rsp_ready_in) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_tag   <= '0;
    end
  end

endmodule

`default_nettype wire

// File: doc/tm_slave_multimaster.md
Name: tm_slave_multimaster

Overview:
- Slave-side credit shell: the NoC-facing wrapper for a slave module that serves requests from several masters.
- Accepts request flits from the NoC, tagged with the source router address and VC, and forwards the data to the slave module.
- Records each request's return tag {src_vc, src} in an in-order FIFO.
- Attaches the FIFO head tag to each reply the module produces, so replies return to the requesting master and return that master's credit.
- Occupancy is capped at NUM_CREDITS, matching the master shell's credit count.

Parameters:
NUM_CREDITS, 32, max outstanding requests; depth of return-tag FIFO; any value >= 1, not necessarily a power of two.
ADDRESS_WIDTH, 4, router address width.
VC_ADDRESS_WIDTH, 2, VC index width.
WIDTH_NOC, 36, flit data width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, asynchronous and active-low (asserted when 0).
req_valid_in  in  1  request flit valid, from NoC.
req_data_in  in  WIDTH_NOC  request flit data.
req_src  in  ADDRESS_WIDTH  requesting master's router address.
req_src_vc  in  VC_ADDRESS_WIDTH  VC the reply must use.
req_ready_out  out  1  shell can accept a request, to NoC.
req_valid_out  out  1  request valid, to slave module.
req_data_out  out  WIDTH_NOC  request data, to slave module.
req_ready_in  in  1  slave module accepts request.
rsp_valid_in  in  1  reply valid, from slave module.
rsp_data_in  in  WIDTH_NOC  reply data.
rsp_ready_out  out  1  shell can accept a reply, to module.
rsp_valid_out  out  1  reply flit valid, to NoC.
rsp_data_out  out  WIDTH_NOC  reply flit data.
rsp_dest  out  ADDRESS_WIDTH  reply destination (popped src).
rsp_vc  out  VC_ADDRESS_WIDTH  reply VC (popped src_vc).
rsp_ready_in  in  1  NoC accepts reply flit.
num_outstanding  out  $clog2(NUM_CREDITS+1)  current tag FIFO occupancy.

Behaviour:
Reset (rst=0, async):
- All outputs 0.
- FIFO read/write pointers 0; occupancy 0; tag storage contents don't-care.
- Reset mid-transfer discards buffered request, reply and all tags; no flit is emitted after release until new input arrives.

Handshake:
- A transfer occurs on a rising edge where valid=1 and ready=1 on the same interface.
- valid/data are held stable until accepted.

Request path (1-entry output register):
- req_ready_out = (~req_valid_out | req_ready_in) & (num_outstanding < NUM_CREDITS); combinational, no dependence on req_valid_in.
- On request accept:
  - req_data_out <= req_data_in; req_valid_out <= 1.
  - Tag {req_src_vc, req_src} written at wr_ptr; wr_ptr advances.
- On module accept with no new request: req_valid_out <= 0.
- Latency NoC->module: 1 cycle. Throughput: 1/cycle while module ready and not full.

Reply path (1-entry output register):
- rsp_ready_out = (~rsp_valid_out | rsp_ready_in) & (num_outstanding != 0).
- On reply accept:
  - rsp_data_out <= rsp_data_in.
  - {rsp_vc, rsp_dest} <= tag at rd_ptr; rsp_valid_out <= 1; rd_ptr advances.
- On NoC accept with no new reply: rsp_valid_out <= 0; rsp_data_out, rsp_dest, rsp_vc <= 0.
- Latency module->NoC: 1 cycle.
- Replies are strictly in request order; the module must reply in order.

Pointers and occupancy:
- Pointers wrap explicitly from NUM_CREDITS-1 to 0 (non-power-of-2 safe).
- num_outstanding: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
- Decrement happens when the reply is accepted from the module, not when it leaves to the NoC.
- Full (num_outstanding == NUM_CREDITS): req_ready_out=0 even if a pop occurs the same cycle (no full bypass).
- Empty: rsp_ready_out=0.
- A push to empty FIFO is poppable the next cycle at the earliest (no same-cycle bypass).

Sim-only checks (translate_off):
- rsp_valid_in=1 while num_outstanding==0 held >16 cycles -> $display("MULTIMASTER UNEXPECTED REPLY"), $stop.
- Push when full or pop when empty -> $display error, $finish.

Test Plan:
1. Single round trip: req data 0x5A, src=3, vc=1, module ready -> req_valid_out 1 cycle later with 0x5A, num_outstanding=1; module replies 0x77 -> rsp_valid_out 1 cycle later, rsp_data_out=0x77, rsp_dest=3, rsp_vc=1, num_outstanding=0.
2. Three masters interleaved, src=1,2,7 back-to-back, module replies in order -> rsp_dest sequence 1,2,7 with matching VCs; no gaps when rsp_ready_in=1.
3. Fill to NUM_CREDITS=4 build with no replies -> req_ready_out=0 after 4th accept. In the cycle a reply is taken, req_ready_out stays 0; it rises the next cycle with num_outstanding=3.
4. Backpressure: rsp_ready_in=0 for 5 cycles -> rsp_valid_out/data/dest held constant and rsp_ready_out=0. Likewise req_ready_in=0 holds req_data_out and drops req_ready_out.
5. Wrap with NUM_CREDITS=3: 10 request/reply pairs with src=i mod 16 -> every rsp_dest=i in order, and pointers wrap correctly past 2.
6. Async reset asserted mid-stream with 2 tags outstanding and rsp_valid_out=1 -> all outputs 0 immediately (before next edge), num_outstanding=0; after release, a fresh request/reply returns the new src.
